// File: rtl/instr_mem_ctrl.sv
// Writable instruction memory with load/run/drain mode control.
// Serves registered fetches over valid/ready with 1-cycle latency.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   prog_en            level request for load mode
//   prog_we            write strobe (honoured in LOAD only)
//   prog_addr/data     write address / data
//   prog_done          pulse: loading complete, go to RUN
//   fetch_req/addr     fetch request and PC
//   fetch_gnt          fetch accepted this cycle (combinational)
//   instr_valid        output register holds a fetched word
//   instr/instr_addr   fetched word and the address it came from
//   instr_ready        consumer accepts instr this cycle
//   mode               00 LOAD, 01 RUN, 10 DRAIN
//   wr_count           writes accepted since LOAD entry, saturating
//   err                sticky error flag
module instr_mem_ctrl #(
    parameter int                 ADDR_W   = 5,
    parameter int                 DATA_W   = 8,
    parameter int                 DEPTH    = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ready,
    output logic [1:0]        mode,
    output logic [ADDR_W:0]   wr_count,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_LOAD  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10
    } state_t;

    state_t state;

    logic [DATA_W-1:0] mem [DEPTH];

    logic in_load;
    logic in_run;
    logic in_drain;
    logic wr_in_range;
    logic rd_in_range;
    logic mem_wr;
    logic wr_sat;
    logic drain_exit;
    logic err_set;
    logic [DATA_W-1:0] rd_word;

    assign in_load  = (state == S_LOAD);
    assign in_run   = (state == S_RUN);
    assign in_drain = (state == S_DRAIN);

    // Widen by one bit so DEPTH == 2**ADDR_W compares correctly.
    assign wr_in_range = ({1'b0, prog_addr} < DEPTH_V);
    assign rd_in_range = ({1'b0, fetch_addr} < DEPTH_V);

    assign mem_wr = in_load & prog_we & wr_in_range;
    assign wr_sat = &wr_count;

    assign fetch_gnt = in_run & fetch_req & (~instr_valid | instr_ready);

    // Leave DRAIN once nothing is held or the held word is taken now.
    assign drain_exit = in_drain & (~instr_valid | instr_ready);

    // Any strobe that does not land is an error, as is a fetch
    // granted to an unimplemented address.
    assign err_set = (prog_we & ~mem_wr) | (fetch_gnt & ~rd_in_range);

    assign rd_word = rd_in_range ? mem[fetch_addr[IDX_W-1:0]] : NOP_WORD;

    assign mode = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_WORD;
            end
        end else if (mem_wr) begin
            mem[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            instr_valid <= 1'b0;
            instr       <= NOP_WORD;
            instr_addr  <= '0;
            wr_count    <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (mem_wr && !wr_sat) begin
                        wr_count <= wr_count + 1'b1;
                    end
                    if (prog_done) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (fetch_gnt) begin
                        instr       <= rd_word;
                        instr_addr  <= fetch_addr;
                        instr_valid <= 1'b1;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                    end
                    if (prog_en) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_exit) begin
                        state       <= S_LOAD;
                        instr_valid <= 1'b0;
                        wr_count    <= '0;
                    end
                end
                default: begin
                    state       <= S_LOAD;
                    instr_valid <= 1'b0;
                    wr_count    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl.
// Driver pushes expected words; a monitor checks presented words.
module tb_instr_mem_ctrl;

    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int DEP = 20;
    localparam logic [DW-1:0] NOP = 8'h13;
    localparam int WR_MAX = 2**(AW+1) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_en = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic          prog_done = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_gnt;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_addr;
    logic          instr_ready = 1'b0;
    logic [1:0]    mode;
    logic [AW:0]   wr_count;
    logic          err;

    instr_mem_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_done(prog_done),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt),
        .instr_valid(instr_valid), .instr(instr),
        .instr_addr(instr_addr), .instr_ready(instr_ready),
        .mode(mode), .wr_count(wr_count), .err(err)
    );

    always #5 clk = ~clk;

    // Reference state: memory image, mode, output occupancy, counters.
    logic [DW-1:0]    mm [2**AW];
    int               mode_m;
    bit               valid_m;
    bit               err_m;
    int               wr_m;
    logic [AW+DW-1:0] q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mm[i]) mm[i] = NOP;
        mode_m  = 0;
        valid_m = 0;
        err_m   = 0;
        wr_m    = 0;
        q.delete();
    endtask

    task automatic cyc(input bit en, input bit we,
                       input logic [AW-1:0] pa,
                       input logic [DW-1:0] pd,
                       input bit done, input bit req,
                       input logic [AW-1:0] fa, input bit rdy);
        bit g;
        @(negedge clk);
        prog_en     = en;
        prog_we     = we;
        prog_addr   = pa;
        prog_data   = pd;
        prog_done   = done;
        fetch_req   = req;
        fetch_addr  = fa;
        instr_ready = rdy;
        #1;
        g = (mode_m == 1) && req && (!valid_m || rdy);
        chk("fetch_gnt", fetch_gnt, g);
        chk("mode", mode, mode_m);
        chk("wr_count", wr_count, wr_m);
        chk("err", err, err_m);
        chk("instr_valid", instr_valid, valid_m);
        if (g) q.push_back({fa, (int'(fa) < DEP) ? mm[fa] : NOP});
        @(posedge clk);
        case (mode_m)
            0: begin
                if (we) begin
                    if (int'(pa) < DEP) begin
                        mm[pa] = pd;
                        if (wr_m < WR_MAX) wr_m++;
                    end else begin
                        err_m = 1;
                    end
                end
                if (done) mode_m = 1;
            end
            1: begin
                if (we) err_m = 1;
                if (g) begin
                    valid_m = 1;
                    if (int'(fa) >= DEP) err_m = 1;
                end else if (rdy) begin
                    valid_m = 0;
                end
                if (en) mode_m = 2;
            end
            default: begin
                if (we) err_m = 1;
                if (!valid_m || rdy) begin
                    mode_m  = 0;
                    valid_m = 0;
                    wr_m    = 0;
                end
            end
        endcase
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(0, 1, a, d, 0, 0, '0, 0);
    endtask

    task automatic done_pulse();
        cyc(0, 0, '0, '0, 1, 0, '0, 0);
    endtask

    task automatic fetch(input logic [AW-1:0] a, input bit rdy);
        cyc(0, 0, '0, '0, 0, 1, a, rdy);
    endtask

    task automatic flush();
        cyc(0, 0, '0, '0, 0, 0, '0, 1);
    endtask

    task automatic to_load();
        for (int i = 0; i < 8 && mode_m != 0; i++) begin
            cyc(1, 0, '0, '0, 0, 0, '0, 1);
        end
    endtask

    // Monitor: checks whatever word the DUT presents, pops on accept.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && instr_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h@%0h expected none",
                             instr, instr_addr);
                end else begin
                    chk("instr", instr, q[0][DW-1:0]);
                    chk("instr_addr", instr_addr, q[0][AW+DW-1:DW]);
                    if (instr_ready) void'(q.pop_front());
                end
            end
        end
    end

    logic [DW-1:0] prog6 [6];

    initial begin
        prog6 = '{8'h21, 8'h62, 8'h83, 8'h44, 8'hE0, 8'hA0};
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, NOP);
        chk("rst_addr", instr_addr, 0);
        chk("rst_wr", wr_count, 0);
        chk("rst_err", err, 0);
        chk("rst_mode", mode, 0);
        rst_n = 1'b1;

        // Fetch without prog_done: nothing granted.
        repeat (3) fetch(5'd3, 1);

        // Load program and stream it out.
        for (int i = 0; i < 6; i++) wr(5'(i), prog6[i]);
        done_pulse();
        for (int i = 0; i < 6; i++) fetch(5'(i), 1);
        flush();

        // Stall with pending request, then release.
        fetch(5'd2, 0);
        repeat (4) cyc(0, 0, '0, '0, 0, 1, 5'd3, 0);
        cyc(0, 0, '0, '0, 0, 1, 5'd4, 1);
        flush();

        // Async reset mid-stall.
        fetch(5'd1, 0);
        fetch(5'd2, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", instr_valid, 0);
        chk("arst_mode", mode, 0);
        chk("arst_instr", instr, NOP);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        done_pulse();
        for (int i = 0; i < 32; i++) fetch(5'(i), 1);
        flush();

        // Drain with a held word, then reload incl. out-of-range write.
        fetch(5'd0, 0);
        fetch(5'd1, 0);
        cyc(1, 0, '0, '0, 0, 1, 5'd5, 0);
        cyc(0, 0, '0, '0, 0, 1, 5'd5, 0);
        cyc(0, 0, '0, '0, 1, 0, '0, 0);
        cyc(0, 0, '0, '0, 0, 0, '0, 1);
        for (int i = 0; i < 6; i++) wr(5'(i), prog6[5-i]);
        wr(5'd25, 8'h77);
        wr(5'd19, 8'h5A);
        done_pulse();
        for (int i = 0; i < 6; i++) fetch(5'(i), 1);
        fetch(5'd25, 1);
        fetch(5'd19, 1);
        flush();
        to_load();
        done_pulse();
        for (int i = 0; i < 6; i++) fetch(5'(i), 1);
        flush();

        // Randomised traffic.
        repeat (1500) begin
            cyc(($urandom % 16) == 0, ($urandom % 4) == 0,
                AW'($urandom), DW'($urandom),
                ($urandom % 8) == 0, ($urandom % 4) != 0,
                AW'($urandom), ($urandom % 3) != 0);
        end

        // Write-counter saturation.
        to_load();
        for (int i = 0; i < 70; i++) begin
            wr(AW'($urandom_range(DEP-1)), DW'($urandom));
        end
        done_pulse();
        for (int i = 0; i < DEP; i++) fetch(5'(i), ($urandom % 2) == 0);
        repeat (3) flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised, writable successor to the fixed program ROM. It holds the CPU program in a register-file memory that a bootloader or test harness loads at run time. It serves fetches through a registered valid/ready interface with 1-cycle latency. It sits between the program loader and the CPU fetch stage, and a 3-state mode FSM gates loading versus execution.

Parameters:
ADDR_W, 5, fetch/program address width.
DATA_W, 8, instruction word width ({opcode, operand} packing is unchanged and opaque here).
DEPTH, 32, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.
NOP_WORD, 0, value returned for cleared or unimplemented locations.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
prog_en  in  1  level request to be in load mode.
prog_we  in  1  write strobe, honoured only in LOAD.
prog_addr  in  ADDR_W  write address.
prog_data  in  DATA_W  write data.
prog_done  in  1  1-cycle pulse: loading complete, enter RUN.
fetch_req  in  1  fetch request.
fetch_addr  in  ADDR_W  fetch address (PC).
fetch_gnt  out  1  request accepted this cycle (combinational).
instr_valid  out  1  output register holds a fetched word.
instr  out  DATA_W  fetched instruction.
instr_addr  out  ADDR_W  address that produced instr.
instr_ready  in  1  consumer accepts instr this cycle.
mode  out  2  00 LOAD, 01 RUN, 10 DRAIN.
wr_count  out  ADDR_W+1  writes accepted since last LOAD entry, saturating.
err  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (async assert, sync release):
  - all DEPTH words = NOP_WORD; mode=LOAD.
  - instr_valid=0, instr=NOP_WORD, instr_addr=0, wr_count=0, err=0.
- LOAD:
  - prog_we with prog_addr<DEPTH writes prog_data at the clock edge and increments wr_count (saturates at 2**(ADDR_W+1)-1).
  - prog_we with prog_addr>=DEPTH: no write, err<=1.
  - fetch_gnt=0.
  - prog_done=1 -> RUN next cycle, whatever prog_en is; a write in the same cycle as prog_done still lands.
  - Entering LOAD from any state clears wr_count to 0.
- RUN:
  - fetch_gnt = fetch_req & (!instr_valid | instr_ready).
  - On a grant, the next edge loads instr=mem[fetch_addr] (NOP_WORD if fetch_addr>=DEPTH, which also sets err<=1), instr_addr=fetch_addr, instr_valid=1. Latency is exactly 1 cycle.
  - instr_ready=1 with no grant -> instr_valid<=0.
  - While instr_valid=1 and instr_ready=0, instr and instr_addr hold stable.
  - Accept and new grant in the same cycle give back-to-back words at 1 word/cycle with no bubble.
  - prog_we in RUN is ignored and sets err<=1.
  - prog_en=1 -> DRAIN. The grant in that same cycle is still honoured.
- DRAIN:
  - fetch_gnt=0; the held word stays presented until accepted.
  - When instr_valid=0, or instr_valid=1 with instr_ready=1 this cycle -> LOAD next cycle, with instr_valid=0.
  - prog_en dropping during DRAIN does not abort; the FSM still goes to LOAD.
  - prog_we in DRAIN is ignored and sets err.
- prog_done outside LOAD has no effect.
- Memory is written only in LOAD, so there is no read/write hazard between the two ports.
- Reset mid-fetch or mid-load: output invalidated and memory re-cleared immediately. No partial state survives.

Test Plan:
1. Reset, then fetch_req addr 3 with prog_done never pulsed -> fetch_gnt=0, instr_valid stays 0, mode=00.
2. Load words {0:8'h21, 1:8'h62, 2:8'h83, 3:8'h44, 4:8'hE0, 5:8'hA0}, pulse prog_done, then fetch 0..5 with instr_ready=1 -> mode=01, wr_count=6, instr sequence 21,62,83,44,E0,A0 one per cycle, each 1 cycle after its grant, instr_addr matching.
3. After the step-2 load, fetch addr 2 and hold instr_ready=0 for 4 cycles with fetch_req=1 -> fetch_gnt=0 throughout, instr=8'h83 and instr_addr=2 stable. Releasing instr_ready grants the next request in that cycle.
4. DEPTH=20 build: LOAD write to addr 25, then RUN fetch addr 25 -> no write, err=1, instr=NOP_WORD with instr_valid=1.
5. RUN with a word stalled, raise prog_en -> mode=10, word held. Assert instr_ready -> next cycle mode=00, instr_valid=0, wr_count=0, and earlier contents still readable after the next prog_done.
6. Assert rst_n=0 asynchronously mid-stall in RUN -> instr_valid=0 and mode=00 without a clock edge. A later fetch after prog_done returns NOP_WORD for every address.
